tick_gen_bank: RTL and testbench

TICK_GEN_BANK -- requirements
Module: tick_gen_bank

---
 rtl/tick_gen_bank.sv | 106 ++++++++++
 tb/tb_tick_gen_bank.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen_bank.sv
// Bank of NUM_CH programmable tick dividers; divisor/mode writes land in a shadow and take effect on wrap or sync.
// Registered outputs: tick/wave change one cycle after the deciding edge, cfg_err one cycle after a rejected write.
module tick_gen_bank #(
   parameter  int NUM_CH  = 3,
   parameter  int CNT_W   = 29,
   parameter  int DEF_DIV = 450000,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              cfg_mode,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] wave,
   output logic              cfg_err
);

   if (DEF_DIV < 2 || longint'(DEF_DIV) >= (longint'(1) << CNT_W) || NUM_CH < 1 || NUM_CH > 8) begin : g_bad_param
      $error("tick_gen_bank: illegal NUM_CH/DEF_DIV for CNT_W");
   end

   localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);

   logic [CNT_W-1:0]  cnt_q  [NUM_CH];
   logic [CNT_W-1:0]  cnt_d  [NUM_CH];
   logic [CNT_W-1:0]  div_q  [NUM_CH];
   logic [CNT_W-1:0]  div_d  [NUM_CH];
   logic [CNT_W-1:0]  sdiv_q [NUM_CH];
   logic [CNT_W-1:0]  sdiv_d [NUM_CH];
   logic [NUM_CH-1:0] mode_q, mode_d, smode_q, smode_d;
   logic [NUM_CH-1:0] tick_q, tick_d, sq_q, sq_d, wave_q, wave_d;
   logic [NUM_CH-1:0] wr_sel;
   logic              err_q, err_d, cfg_ok;

   always_comb begin
      cfg_ok = (cfg_div >= CNT_W'(2)) && (int'(cfg_ch) < NUM_CH);
      err_d  = cfg_we && !cfg_ok;
      for (int i = 0; i < NUM_CH; i++) begin
         wr_sel[i]  = cfg_we && cfg_ok && (int'(cfg_ch) == i);
         sdiv_d[i]  = wr_sel[i] ? cfg_div  : sdiv_q[i];
         smode_d[i] = wr_sel[i] ? cfg_mode : smode_q[i];
         cnt_d[i]   = cnt_q[i];
         div_d[i]   = div_q[i];
         mode_d[i]  = mode_q[i];
         sq_d[i]    = sq_q[i];
         tick_d[i]  = 1'b0;
         // sync takes the post-write shadow so a same-edge write applies immediately
         if (sync) begin
            cnt_d[i]  = '0;
            sq_d[i]   = 1'b0;
            div_d[i]  = sdiv_d[i];
            mode_d[i] = smode_d[i];
         end else if (en && ch_en[i]) begin
            if (cnt_q[i] == div_q[i] - CNT_W'(1)) begin
               cnt_d[i]  = '0;
               tick_d[i] = 1'b1;
               sq_d[i]   = 1'b0;
               div_d[i]  = sdiv_q[i];
               mode_d[i] = smode_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
               sq_d[i]  = (cnt_d[i] >= (div_q[i] >> 1));
            end
         end
         wave_d[i] = mode_d[i] ? sq_d[i] : tick_d[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]  <= '0;
            div_q[i]  <= DEF_DIV_W;
            sdiv_q[i] <= DEF_DIV_W;
         end
         mode_q  <= '0;
         smode_q <= '0;
         tick_q  <= '0;
         sq_q    <= '0;
         wave_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]  <= cnt_d[i];
            div_q[i]  <= div_d[i];
            sdiv_q[i] <= sdiv_d[i];
         end
         mode_q  <= mode_d;
         smode_q <= smode_d;
         tick_q  <= tick_d;
         sq_q    <= sq_d;
         wave_q  <= wave_d;
         err_q   <= err_d;
      end
   end

   assign tick    = tick_q;
   assign wave    = wave_q;
   assign cfg_err = err_q;

endmodule

// File: tb/tb_tick_gen_bank.sv
// Directed bench for tick_gen_bank with NUM_CH=2, CNT_W=8, DEF_DIV=4.
// Inputs set 1 time unit after a rising edge; k counts rising edges since reset release.
module tb_tick_gen_bank;
   localparam int NUM_CH  = 2;
   localparam int CNT_W   = 8;
   localparam int DEF_DIV = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             en = 1'b1;
   logic [1:0]       ch_en = 2'b11;
   logic             sync = 1'b0;
   logic             cfg_we = 1'b0;
   logic [0:0]       cfg_ch = 1'b0;
   logic [7:0]       cfg_div = 8'd0;
   logic             cfg_mode = 1'b0;
   logic [1:0]       tick, wave;
   logic             cfg_err;
   int               n_cmp = 0;
   int               n_bad = 0;

   tick_gen_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .ch_en(ch_en), .sync(sync),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
      .tick(tick), .wave(wave), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; en = 1'b1; ch_en = 2'b11; sync = 1'b0;
      cfg_we = 1'b0; cfg_ch = 1'b0; cfg_div = 8'd0; cfg_mode = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (tick !== 2'b00) begin n_bad++; $display("FAIL reset_tick got %b exp 00", tick); end
      n_cmp++; if (wave !== 2'b00) begin n_bad++; $display("FAIL reset_wave got %b exp 00", wave); end
      n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", cfg_err); end
      step();
      step();
      n_cmp++; if (tick !== 2'b00 || wave !== 2'b00) begin n_bad++; $display("FAIL reset_hold got tick %b wave %b exp 00", tick, wave); end
      rst_n = 1'b1;
      step();
      n_cmp++; if (tick !== 2'b00 || wave !== 2'b00) begin n_bad++; $display("FAIL reset_first_edge got tick %b wave %b exp 00", tick, wave); end
   endtask

   task automatic test_basic();
      logic [1:0] et;
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         step();
         et = (k % 4 == 0) ? 2'b11 : 2'b00;
         n_cmp++; if (tick !== et) begin n_bad++; $display("FAIL basic_tick k=%0d got %b exp %b", k, tick, et); end
         n_cmp++; if (wave !== et) begin n_bad++; $display("FAIL basic_wave k=%0d got %b exp %b", k, wave, et); end
      end
   endtask

   task automatic test_cfg_write();
      logic [1:0] et;
      logic       ew0;
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         cfg_we = (k == 2); cfg_ch = 1'b0; cfg_div = 8'd5; cfg_mode = 1'b1;
         step();
         et  = {(k % 4 == 0), (k >= 4) && ((k - 4) % 5 == 0)};
         ew0 = ((k - 4) % 5) >= 2;
         n_cmp++; if (tick !== et) begin n_bad++; $display("FAIL cfgw_tick k=%0d got %b exp %b", k, tick, et); end
         n_cmp++; if (wave[1] !== et[1]) begin n_bad++; $display("FAIL cfgw_wave1 k=%0d got %b exp %b", k, wave[1], et[1]); end
         if (k >= 5) begin
            n_cmp++; if (wave[0] !== ew0) begin n_bad++; $display("FAIL cfgw_wave0 k=%0d got %b exp %b", k, wave[0], ew0); end
         end
      end
      cfg_we = 1'b0; cfg_mode = 1'b0;
   endtask

   task automatic test_cfg_err();
      logic [1:0] et;
      logic       ee;
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         cfg_we  = (k == 2) || (k == 3) || (k == 5);
         cfg_div = (k == 2) ? 8'd1 : (k == 3) ? 8'd0 : 8'd4;
         cfg_ch  = (k == 3) ? 1'b1 : 1'b0;
         step();
         et = (k % 4 == 0) ? 2'b11 : 2'b00;
         ee = (k == 2) || (k == 3);
         n_cmp++; if (cfg_err !== ee) begin n_bad++; $display("FAIL cfgerr_flag k=%0d got %b exp %b", k, cfg_err, ee); end
         n_cmp++; if (tick !== et) begin n_bad++; $display("FAIL cfgerr_tick k=%0d got %b exp %b", k, tick, et); end
      end
      cfg_we = 1'b0;
   endtask

   task automatic test_ch_disable();
      logic [1:0] et;
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         ch_en = (k >= 2 && k <= 4) ? 2'b01 : 2'b11;
         step();
         et = {(k >= 7) && ((k - 7) % 4 == 0), (k % 4 == 0)};
         n_cmp++; if (tick !== et) begin n_bad++; $display("FAIL chdis_tick k=%0d got %b exp %b", k, tick, et); end
      end
      ch_en = 2'b11;
   endtask

   task automatic test_sync();
      logic [1:0] et;
      do_reset();
      for (int k = 1; k <= 3; k++) begin
         cfg_we = (k == 1); cfg_ch = 1'b1; cfg_div = 8'd6; cfg_mode = 1'b0;
         sync = (k == 3);
         step();
         n_cmp++; if (tick !== 2'b00) begin n_bad++; $display("FAIL sync_pre k=%0d got %b exp 00", k, tick); end
      end
      sync = 1'b0; cfg_we = 1'b0;
      for (int j = 1; j <= 12; j++) begin
         step();
         et = {(j % 6 == 0), (j % 4 == 0)};
         n_cmp++; if (tick !== et) begin n_bad++; $display("FAIL sync_tick j=%0d got %b exp %b", j, tick, et); end
      end
      for (int m = 1; m <= 7; m++) begin
         sync = (m == 1); cfg_we = (m == 1); cfg_ch = 1'b0; cfg_div = 8'd3; cfg_mode = 1'b0;
         step();
         et = {(m > 1) && ((m - 1) % 6 == 0), (m > 1) && ((m - 1) % 3 == 0)};
         n_cmp++; if (tick !== et) begin n_bad++; $display("FAIL syncwr_tick m=%0d got %b exp %b", m, tick, et); end
      end
      sync = 1'b0; cfg_we = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [1:0] et;
      do_reset();
      for (int k = 1; k <= 14; k++) begin
         cfg_we = (k == 2) || (k == 3); cfg_ch = 1'b0; cfg_mode = 1'b0;
         cfg_div = (k == 2) ? 8'd6 : 8'd5;
         step();
         et = {(k % 4 == 0), (k >= 4) && ((k - 4) % 5 == 0)};
         n_cmp++; if (tick !== et) begin n_bad++; $display("FAIL b2b_tick k=%0d got %b exp %b", k, tick, et); end
      end
      cfg_we = 1'b0;
   endtask

   task automatic test_wrap_write();
      logic [1:0] et;
      do_reset();
      for (int k = 1; k <= 18; k++) begin
         cfg_we = (k == 4); cfg_ch = 1'b0; cfg_div = 8'd5; cfg_mode = 1'b0;
         step();
         et = {(k % 4 == 0), (k == 4) || ((k >= 8) && ((k - 8) % 5 == 0))};
         n_cmp++; if (tick !== et) begin n_bad++; $display("FAIL wrapwr_tick k=%0d got %b exp %b", k, tick, et); end
      end
      cfg_we = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [1:0] et;
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         cfg_we = (k == 4); cfg_ch = 1'b0; cfg_div = 8'd5; cfg_mode = 1'b1;
         step();
      end
      cfg_we = 1'b0; cfg_mode = 1'b0;
      n_cmp++; if (tick !== 2'b11 || wave !== 2'b11) begin n_bad++; $display("FAIL rstmid_pre got tick %b wave %b exp 11", tick, wave); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (tick !== 2'b00) begin n_bad++; $display("FAIL rstmid_tick got %b exp 00", tick); end
      n_cmp++; if (wave !== 2'b00) begin n_bad++; $display("FAIL rstmid_wave got %b exp 00", wave); end
      n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_err got %b exp 0", cfg_err); end
      step();
      rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         et = (k % 4 == 0) ? 2'b11 : 2'b00;
         n_cmp++; if (tick !== et) begin n_bad++; $display("FAIL rstmid_post_tick k=%0d got %b exp %b", k, tick, et); end
         n_cmp++; if (wave !== et) begin n_bad++; $display("FAIL rstmid_post_wave k=%0d got %b exp %b", k, wave, et); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_cfg_write();
      test_cfg_err();
      test_ch_disable();
      test_sync();
      test_back_to_back();
      test_wrap_write();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
